// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks every N-bit input combination into two combinational implementations
//   of one Boolean function and compares their outputs. It reports:
//   - the minterm mask and minterm count of implementation A,
//   - whether A and B agree everywhere,
//   - the lowest combination at which they disagree.
//
// Parameters
//   N      : number of function inputs (1..6)
//   SETTLE : extra cycles each combination is held before sampling (0..15)
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start, abort    : begin a sweep (IDLE only) / cancel a sweep in RUN
//   vec   [N-1:0]   : combination currently driven to both implementations
//   fa, fb          : implementation A / B outputs for vec
//   busy            : high while sweeping
//   done            : one-cycle completion pulse
//   mask  [2^N-1:0] : bit i = fa sampled at vec = i
//   ones  [N:0]     : popcount of mask
//   equal           : fa == fb at every combination
//   first_diff      : lowest vec with fa != fb (0 when equal)
module truth_table_sweeper #(
  parameter int N      = 3,
  parameter int SETTLE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  output logic [N-1:0]        vec,
  input  logic                fa,
  input  logic                fb,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   mask,
  output logic [N:0]          ones,
  output logic                equal,
  output logic [N-1:0]        first_diff
);

  localparam int          M         = 1 << N;
  localparam logic [3:0]  HOLD_INIT = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   vec_q, vec_d;
  logic [3:0]     hold_q, hold_d;
  logic [M-1:0]   mask_q, mask_d;
  logic [N:0]     ones_q, ones_d;
  logic           equal_q, equal_d;
  logic [N-1:0]   fd_q, fd_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      mask_q  <= '0;
      ones_q  <= '0;
      equal_q <= 1'b0;
      fd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      mask_q  <= mask_d;
      ones_q  <= ones_d;
      equal_q <= equal_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    mask_d  = mask_q;
    ones_d  = ones_q;
    equal_d = equal_q;
    fd_d    = fd_q;
    case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d = RUN;
          vec_d   = '0;
          hold_d  = HOLD_INIT;
          mask_d  = '0;
          ones_d  = '0;
          equal_d = 1'b1;
          fd_d    = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          hold_d  = '0;
          mask_d  = '0;
          ones_d  = '0;
          equal_d = 1'b0;
          fd_d    = '0;
        end else if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else begin
          // last edge of this combination's hold window: sample fa/fb
          mask_d[vec_q] = fa;
          ones_d        = ones_q + {{N{1'b0}}, fa};
          if ((fa != fb) && equal_q) begin
            equal_d = 1'b0;
            fd_d    = vec_q;
          end
          if (&vec_q) begin
            state_d = DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = HOLD_INIT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // status flags are registered decodes of the next state
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign mask       = mask_q;
  assign ones       = ones_q;
  assign equal      = equal_q;
  assign first_diff = fd_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively drives every input combination into two combinational Boolean implementations of the same function, such as a sum-of-products form and a product-of-sums form. It samples both outputs at each combination and reports the results. Reported results are the minterm mask and minterm count of the first implementation, whether the two implementations agree, and the index of the first disagreement. It sits between a start/done control interface and the evaluated function modules, replacing hand-written stimulus sequences for truth-table checking.

## Interface
- N, default 3: number of function inputs; legal 1..6.
- SETTLE, default 0: extra cycles each combination is held before sampling; legal 0..15.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  cancel a sweep in progress.
- vec  out  N  current input combination; vec[N-1] is the most significant variable (x), vec[0] the least.
- fa  in  1  output of implementation A (e.g. SoP) for vec.
- fb  in  1  output of implementation B (e.g. PoS) for vec.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at sweep completion.
- mask  out  2^N  bit i = fa sampled at vec = i.
- ones  out  N+1  number of ones in mask.
- equal  out  1  1 if fa == fb at every combination.
- first_diff  out  N  lowest vec with fa != fb; 0 when equal = 1.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: vec = 0, busy = 0, done = 0, mask = 0, ones = 0, equal = 0, first_diff = 0, hold counter = 0, state = IDLE.
- **IDLE, start = 1 and abort = 0:**
  - Go to RUN.
  - vec <= 0, hold counter <= SETTLE.
  - mask <= 0, ones <= 0, equal <= 1, first_diff <= 0.
- **IDLE, start = 1 and abort = 1:** stay in IDLE; abort has priority.
- **RUN, hold counter != 0:** decrement the hold counter; vec is unchanged.
- **RUN, hold counter == 0:** sample on this edge.
  - mask[vec] <= fa; ones <= ones + fa.
  - If fa != fb and equal == 1: equal <= 0 and first_diff <= vec. Only the first mismatch is recorded.
  - If vec == 2^N-1: go to DONE. vec holds its final value.
  - Otherwise: vec <= vec + 1 and hold counter <= SETTLE.
- **RUN, abort = 1:** overrides sampling.
  - Go to IDLE.
  - vec, mask, ones, equal and first_diff return to their reset values; done is not pulsed.
- start during RUN or DONE is ignored.
- **DONE:** done = 1 for exactly one cycle, then IDLE. abort in DONE is ignored.
- Results (mask, ones, equal, first_diff) are valid from the done cycle and hold until the next accepted start, an abort, or reset.
- After done, vec returns to 0 on the transition to IDLE.
- ones never wraps: its maximum is 2^N, which fits in N+1 bits.
- reset = 1 in any state returns to reset values on that edge, including mid-sweep.

## Timing
- busy is a registered decode of RUN; done is a registered decode of DONE.
- **Start acceptance:** start is sampled high at edge k. busy is 1 from edge k; vec = 0 is driven from edge k.
- **Hold per combination:** each vec value is held for SETTLE+1 cycles. fa and fb are sampled at the last edge of that hold window.
- **Sweep length:** RUN lasts exactly 2^N·(SETTLE+1) cycles.
- **Completion:** done is high from edge k + 2^N·(SETTLE+1) for one cycle, with busy = 0 in that cycle.
- **Restart:** the earliest next accepted start is the edge that ends the done cycle plus one, i.e. the first IDLE cycle.
- fa and fb must settle within SETTLE+1 cycles of a vec change; the block places no further requirement on them.

## Test plan
- **XOR against single variable:**
  - Stimulus: N=2, SETTLE=1, fa = vec[1]^vec[0], fb = vec[1]; start.
  - Required: mask = 4'b0110, ones = 2, equal = 0, first_diff = 1, done exactly 8 cycles after start acceptance.
- **Identical implementations:**
  - Stimulus: N=3, SETTLE=0, fa = fb = (~vec[2] | vec[1]) & (vec[1] | vec[0]); start.
  - Required: mask = 8'b11001110, ones = 5, equal = 1, first_diff = 0, done 8 cycles after start, busy high for 8 cycles.
- **Abort mid-sweep:**
  - Stimulus: N=3, assert abort at vec = 4.
  - Required: next cycle IDLE, busy = 0, no done pulse, mask = 0, equal = 0.
  - Then: a new start completes a full sweep normally.
- **Ignored and simultaneous controls:**
  - start pulsed repeatedly during RUN -> no restart; done at the nominal cycle.
  - start and abort together in IDLE -> stays IDLE.
  - start in the done cycle -> ignored.
- **Synchronous reset mid-sweep:** reset held one cycle at vec = 5 -> every output at its reset value after that edge; no done pulse.
- **Settle window:**
  - Stimulus: fb = fa delayed through a 2-stage register.
  - Required: SETTLE=3 -> equal = 1. SETTLE=0 with a non-constant fa -> equal = 0, first_diff = lowest index at which fa differs from the value fa had at index−2 (fb during the first two combinations is the register reset value).
